// File: rtl/bool_tt_scanner_if.sv
// Control and block-under-check signals of the truth-table scanner, grouped for
// the master (controller/testbench) and slave (scanner) sides.
interface bool_tt_scanner_if #(
    parameter int N_IN = 3
);
    // Handshake: master raises start (level, sampled only while the scanner is idle);
    // the scanner answers with busy from the next cycle and a single-cycle done,
    // after which pass/err_cnt/fail_idx/cap_tt stay valid until the next accepted start.
    logic                 start;
    logic [N_IN-1:0]      drv_in;
    logic                 dut_y;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_cnt;
    logic [N_IN-1:0]      fail_idx;
    logic [2**N_IN-1:0]   cap_tt;

    modport master (
        output start,
        output dut_y,
        input  drv_in,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  fail_idx,
        input  cap_tt
    );

    modport slave (
        input  start,
        input  dut_y,
        output drv_in,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output fail_idx,
        output cap_tt
    );
endinterface

// File: rtl/bool_tt_scanner.sv
// Walks every input vector of an N_IN-input block, samples its output after a settle
// time and compares against EXP_TT. Optional macro: TT_STOP_ON_FAIL_EN (stop at first mismatch).
module bool_tt_scanner #(
    parameter int                 N_IN       = 3,
    parameter int                 SETTLE_CYC = 2,
    parameter logic [2**N_IN-1:0] EXP_TT     = 8'hE8
) (
    input  logic              clk,
    input  logic              rst,
    bool_tt_scanner_if.slave  bus,
    output logic [1:0]        dbg_state
);
    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

`ifdef TT_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [N_IN-1:0]    drv_in;
    logic               busy;
    logic               done;
    logic               pass;
    logic [N_IN:0]      err_cnt;
    logic [N_IN-1:0]    fail_idx;
    logic [NV-1:0]      cap_tt;

    logic               mismatch;
    logic [N_IN:0]      err_nxt;
    logic               last_vec;

    // drv_in doubles as the scan index: it always equals the vector being checked.
    always_comb begin
        mismatch = (bus.dut_y != EXP_TT[drv_in]);
        err_nxt  = err_cnt + {{N_IN{1'b0}}, mismatch};
        last_vec = (drv_in == LAST_IDX) || (STOP_ON_FAIL && mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            drv_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_idx <= '0;
            cap_tt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= SETTLE;
                        drv_in   <= '0;
                        busy     <= 1'b1;
                        cnt      <= CNT_LOAD;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        fail_idx <= '0;
                        cap_tt   <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    cap_tt[drv_in] <= bus.dut_y;
                    err_cnt        <= err_nxt;
                    if (mismatch && (err_cnt == '0)) begin
                        fail_idx <= drv_in;
                    end
                    // done and pass are registered here so they appear in the DONE cycle.
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        state  <= SETTLE;
                        drv_in <= drv_in + N_IN'(1);
                        cnt    <= CNT_LOAD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.drv_in   = drv_in;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.pass     = pass;
    assign bus.err_cnt  = err_cnt;
    assign bus.fail_idx = fail_idx;
    assign bus.cap_tt   = cap_tt;
    assign dbg_state    = state;
endmodule

// File: tb/tb_bool_tt_scanner.sv
// Bench for bool_tt_scanner: cycle-level timeline model plus whole-scan result queue,
// directed cases and randomized block tables.
module tb_bool_tt_scanner;
    localparam int N_IN       = 3;
    localparam int NV         = 8;
    localparam int SETTLE_CYC = 2;
    localparam int VEC_CYC    = SETTLE_CYC + 1;
    localparam logic [NV-1:0] EXP_TT = 8'hE8;
`ifdef TT_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bool_tt_scanner_if #(.N_IN(N_IN)) bus ();
    logic [1:0]    dbg_state;
    logic [NV-1:0] blk_tt;
    logic [NV-1:0] maj_tt;

    // Block under check: a plain lookup of its truth table.
    assign bus.dut_y = blk_tt[bus.drv_in];

    bool_tt_scanner #(
        .N_IN(N_IN), .SETTLE_CYC(SETTLE_CYC), .EXP_TT(EXP_TT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-scan outcome from the table rules: {pass, err_cnt, fail_idx, cap_tt}.
    function automatic logic [15:0] summarize(input logic [NV-1:0] blk);
        logic [3:0]    e = '0;
        logic [2:0]    f = '0;
        logic [NV-1:0] c = '0;
        bit            stopped = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (!stopped) begin
                c[i] = blk[i];
                if (blk[i] != EXP_TT[i]) begin
                    if (e == 0) f = 3'(i);
                    e++;
                    if (STOP) stopped = 1'b1;
                end
            end
        end
        return {(e == 0), e, f, c};
    endfunction

    // ---------------- timeline model ----------------
    logic [15:0] exp_q[$];
    int          m_phase;   // 0 idle, 1 scanning, 2 done cycle
    int          m_t;
    int          m_i;
    bit          m_mm;
    logic        m_busy, m_done, m_pass;
    logic [3:0]  m_err;
    logic [2:0]  m_fail, m_drv;
    logic [7:0]  m_cap;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_t = 0;
            m_busy = 0; m_done = 0; m_pass = 0;
            m_err = 0; m_fail = 0; m_drv = 0; m_cap = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_phase = 1; m_t = 0;
                    m_busy = 1; m_drv = 0; m_pass = 0;
                    m_err = 0; m_fail = 0; m_cap = 0;
                    exp_q.push_back(summarize(blk_tt));
                end
                1: begin
                    m_t++;
                    // vector i is sampled on edge VEC_CYC*(i+1) after acceptance
                    if (m_t % VEC_CYC == 0) begin
                        m_i  = m_t / VEC_CYC - 1;
                        m_mm = (blk_tt[m_i] != EXP_TT[m_i]);
                        m_cap[m_i] = blk_tt[m_i];
                        if (m_mm) begin
                            if (m_err == 0) m_fail = 3'(m_i);
                            m_err++;
                        end
                        if (m_i == NV - 1 || (STOP && m_mm)) begin
                            m_phase = 2; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                        end else begin
                            m_drv = 3'(m_i + 1);
                        end
                    end
                end
                default: begin
                    m_done = 0; m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] got_res;
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     bus.busy,     m_busy);
            check("done",     bus.done,     m_done);
            check("pass",     bus.pass,     m_pass);
            check("err_cnt",  bus.err_cnt,  m_err);
            check("fail_idx", bus.fail_idx, m_fail);
            check("cap_tt",   bus.cap_tt,   m_cap);
            check("drv_in",   bus.drv_in,   m_drv);
            if (bus.done === 1'b1) begin
                got_res = {bus.pass, bus.err_cnt, bus.fail_idx, bus.cap_tt};
                if (exp_q.size() == 0) begin
                    check("result_queued", 0, 1);
                end else begin
                    check("scan_result", got_res, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    endtask

    // Start a scan and return the cycle (1 = first cycle after the start edge) where done rose.
    task automatic run_scan(input bit hold, input bit repulse, output int lat);
        bit seen = 1'b0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        lat = 0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (repulse) bus.start = (lat == 5 || lat == 12);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic check_results(input string tag, input int lat, input int exp_lat,
                                 input logic pass, input logic [3:0] err,
                                 input logic [2:0] fidx, input logic [7:0] cap);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_pass"},    bus.pass,     pass);
        check({tag, "_err"},     bus.err_cnt,  err);
        check({tag, "_fidx"},    bus.fail_idx, fidx);
        check({tag, "_cap"},     bus.cap_tt,   cap);
    endtask

    // ---------------- main sequence ----------------
    int          lat;
    int          cnt;
    int          last_i;
    logic [15:0] r;

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < NV; i++) begin
            maj_tt[i] = (i[2] & i[1]) | (i[2] & i[0]) | (i[1] & i[0]);
        end
        blk_tt = maj_tt;
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_cap",  bus.cap_tt, 0);
        check("rst_err",  bus.err_cnt, 0);

        // majority block: clean pass
        run_scan(1'b0, 1'b0, lat);
        check_results("maj", lat, 25, 1'b1, 4'd0, 3'd0, 8'hE8);

        // stuck-at-0 block
        blk_tt = 8'h00;
        run_scan(1'b0, 1'b0, lat);
        check_results("stuck0", lat, STOP ? 13 : 25, 1'b0, STOP ? 4'd1 : 4'd4, 3'd3, 8'h00);

        // start re-pulsed mid-scan is ignored
        blk_tt = maj_tt;
        run_scan(1'b0, 1'b1, lat);
        bus.start = 1'b0;
        check_results("repulse", lat, 25, 1'b1, 4'd0, 3'd0, 8'hE8);

        // reset in the middle of vector 4
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("mid_drv_in", bus.drv_in, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_drv",  bus.drv_in, 0);
        check("midrst_cap",  bus.cap_tt, 0);
        check("midrst_err",  bus.err_cnt, 0);
        run_scan(1'b0, 1'b0, lat);
        check_results("after_rst", lat, 25, 1'b1, 4'd0, 3'd0, 8'hE8);

        // block wrong only at vector 5
        blk_tt = maj_tt ^ 8'h20;
        run_scan(1'b0, 1'b0, lat);
        check_results("inv5", lat, STOP ? 19 : 25, 1'b0, 4'd1, 3'd5, STOP ? 8'h08 : 8'hC8);

        // start held across done re-arms
        blk_tt = maj_tt;
        run_scan(1'b1, 1'b0, lat);
        check("hold_lat", lat, 25);
        @(negedge clk);
        check("hold_idle_busy", bus.busy, 0);
        @(negedge clk);
        check("rearm_busy", bus.busy, 1);
        check("rearm_cap",  bus.cap_tt, 0);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("rearm_lat", cnt, 24);
        check("rearm_cap_end", bus.cap_tt, 8'hE8);

        // random block tables
        for (int n = 0; n < 10; n++) begin
            blk_tt = 8'($urandom_range(0, 255));
            r = summarize(blk_tt);
            last_i = (STOP && r[14:11] != 0) ? int'(r[10:8]) : NV - 1;
            run_scan(1'b0, 1'b0, lat);
            check_results("rand", lat, VEC_CYC * (last_i + 1) + 1, r[15], r[14:11], r[10:8], r[7:0]);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
